// File: rtl/sram_dp_be.sv
// Simple dual-port SRAM with byte-lane write enables, 1- or 2-cycle read latency,
// selectable read-during-write behaviour and a one-word-per-cycle clear engine.
module sram_dp_be #(
  parameter int DATAWIDTH  = 32,
  parameter int ADDRWIDTH  = 6,
  parameter int BYTEWIDTH  = 8,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ce,
  input  logic                           wr_en,
  input  logic [ADDRWIDTH-1:0]           wr_addr,
  input  logic [DATAWIDTH/BYTEWIDTH-1:0] wr_be,
  input  logic [DATAWIDTH-1:0]           din,
  input  logic                           rd_en,
  input  logic [ADDRWIDTH-1:0]           rd_addr,
  output logic [DATAWIDTH-1:0]           dout,
  output logic                           dout_valid,
  input  logic                           clr_start,
  output logic                           busy,
  output logic                           clr_done
);

  localparam int NBE   = DATAWIDTH / BYTEWIDTH;
  localparam int DEPTH = 2 ** ADDRWIDTH;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                 state_q, state_d;
  logic [ADDRWIDTH-1:0]   ptr_q, ptr_d;
  logic                   done_d;
  logic                   clr_wr, wr_acc, rd_acc;
  logic [DATAWIDTH-1:0]   mem [DEPTH];
  logic [DATAWIDTH-1:0]   rd_word;
  logic [DATAWIDTH-1:0]   data_p0;
  logic                   vld_p0;

  function automatic logic [DATAWIDTH-1:0] merge_lanes(
    input logic [DATAWIDTH-1:0] old_word,
    input logic [DATAWIDTH-1:0] new_word,
    input logic [NBE-1:0]       be
  );
    logic [DATAWIDTH-1:0] res;
    res = old_word;
    for (int k = 0; k < NBE; k++) begin
      if (be[k]) res[k*BYTEWIDTH +: BYTEWIDTH] = new_word[k*BYTEWIDTH +: BYTEWIDTH];
    end
    return res;
  endfunction

  assign busy   = (state_q == CLEAR);
  assign clr_wr = busy & ~reset;
  assign wr_acc = ce & wr_en & ~busy & ~clr_start & ~reset;
  assign rd_acc = ce & rd_en & ~busy & ~clr_start & ~reset;

  // Clear engine: next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + ADDRWIDTH'(1);
        if (ptr_q == ADDRWIDTH'(DEPTH - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= CLEAR;
      ptr_q    <= '0;
      clr_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      clr_done <= done_d;
    end
  end

  // Storage: the clear engine owns the array while busy
  always_ff @(posedge clk) begin
    if (clr_wr) begin
      mem[ptr_q] <= '0;
    end else if (wr_acc) begin
      for (int k = 0; k < NBE; k++) begin
        if (wr_be[k]) mem[wr_addr][k*BYTEWIDTH +: BYTEWIDTH] <= din[k*BYTEWIDTH +: BYTEWIDTH];
      end
    end
  end

  always_comb begin
    rd_word = mem[rd_addr];
    if (RDW_MODE == 1 && wr_acc && (wr_addr == rd_addr)) begin
      rd_word = merge_lanes(mem[rd_addr], din, wr_be);
    end
  end

  // Stage p0: array read register
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else begin
      vld_p0 <= rd_acc;
      if (rd_acc) data_p0 <= rd_word;
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [DATAWIDTH-1:0] data_p1;
      logic                 vld_p1;

      // Stage p1: optional output register
      always_ff @(posedge clk) begin
        if (reset) begin
          vld_p1  <= 1'b0;
          data_p1 <= '0;
        end else begin
          vld_p1 <= vld_p0;
          if (vld_p0) data_p1 <= data_p0;
        end
      end

      assign dout       = data_p1;
      assign dout_valid = vld_p1;
    end else begin : g_lat1
      assign dout       = data_p0;
      assign dout_valid = vld_p0;
    end
  endgenerate

endmodule

// File: tb/tb_sram_dp_be.sv
// Scoreboard bench for sram_dp_be: two instances (latency 1 / old-data, latency 2 / new-data)
// share stimulus; each has its own expected-read queue drained by a monitor.
module tb_sram_dp_be;

  localparam int DW = 32;
  localparam int AW = 4;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, ce, wr_en, rd_en, clr_start;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [3:0]    wr_be;
  logic [DW-1:0] din;
  logic [DW-1:0] dout_a, dout_b;
  logic          dout_valid_a, dout_valid_b, busy_a, busy_b, clr_done_a, clr_done_b;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_dp_be #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .BYTEWIDTH(8), .RD_LATENCY(1), .RDW_MODE(0)) dut_a (
    .clk(clk), .reset(reset), .ce(ce), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .din(din), .rd_en(rd_en), .rd_addr(rd_addr), .dout(dout_a), .dout_valid(dout_valid_a),
    .clr_start(clr_start), .busy(busy_a), .clr_done(clr_done_a)
  );

  sram_dp_be #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .BYTEWIDTH(8), .RD_LATENCY(2), .RDW_MODE(1)) dut_b (
    .clk(clk), .reset(reset), .ce(ce), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .din(din), .rd_en(rd_en), .rd_addr(rd_addr), .dout(dout_b), .dout_valid(dout_valid_b),
    .clr_start(clr_start), .busy(busy_b), .clr_done(clr_done_b)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: every dout_valid must match the oldest expected read, on its due cycle
  always @(negedge clk) begin
    if (dout_valid_a) begin
      if (qa.size() == 0) begin
        chk("a_spurious_valid", 32'd1, 32'd0);
      end else begin
        chk("a_rd_data", dout_a, qa[0].data);
        chk("a_rd_cycle", DW'(cyc), DW'(qa[0].due));
        void'(qa.pop_front());
      end
    end else if (qa.size() > 0 && qa[0].due <= cyc) begin
      chk("a_missing_valid", 32'd0, 32'd1);
      void'(qa.pop_front());
    end
  end

  always @(negedge clk) begin
    if (dout_valid_b) begin
      if (qb.size() == 0) begin
        chk("b_spurious_valid", 32'd1, 32'd0);
      end else begin
        chk("b_rd_data", dout_b, qb[0].data);
        chk("b_rd_cycle", DW'(cyc), DW'(qb[0].due));
        void'(qb.pop_front());
      end
    end else if (qb.size() > 0 && qb[0].due <= cyc) begin
      chk("b_missing_valid", 32'd0, 32'd1);
      void'(qb.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ce = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_start = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_be = '0; din = '0;
  endtask

  task automatic push_rd(input logic [DW-1:0] ea, input logic [DW-1:0] eb);
    exp_t e;
    e.data = ea; e.due = cyc + 1; qa.push_back(e);
    e.data = eb; e.due = cyc + 2; qb.push_back(e);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    ce = 1'b1; wr_en = 1'b1; wr_addr = a; din = d; wr_be = be;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] ea, input logic [DW-1:0] eb);
    ce = 1'b1; rd_en = 1'b1; rd_addr = a;
    push_rd(ea, eb);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic drain();
    repeat (4) tick();
    chk("queue_a_empty", DW'(qa.size()), 32'd0);
    chk("queue_b_empty", DW'(qb.size()), 32'd0);
  endtask

  // Counts busy cycles and clr_done pulses; optionally hammers both ports meanwhile
  task automatic wait_clear(input string name, input bit spam);
    int cnt = 0;
    int dn  = 0;
    if (spam) begin
      ce = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; din = 32'h5A5A5A5A; wr_be = 4'hF;
      rd_en = 1'b1; rd_addr = 4'd0;
    end
    while (busy_a && cnt < 100) begin
      tick();
      cnt++;
      if (clr_done_a) dn++;
      if (clr_done_b) dn++;
    end
    idle_inputs();
    chk({name, "_busy_cycles"}, DW'(cnt), 32'd16);
    chk({name, "_done_pulses"}, DW'(dn), 32'd2);
    chk({name, "_busy_b"}, {31'd0, busy_b}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    // 1: reset and initial clear
    tick(); tick();
    chk("rst_dout_a", dout_a, 32'd0);
    chk("rst_dout_b", dout_b, 32'd0);
    chk("rst_valid", {30'd0, dout_valid_a, dout_valid_b}, 32'd0);
    chk("rst_busy", {30'd0, busy_a, busy_b}, 32'd3);
    chk("rst_done", {30'd0, clr_done_a, clr_done_b}, 32'd0);
    reset = 1'b0;
    wait_clear("init", 1'b0);
    rd(4'd5, 32'h0, 32'h0);
    drain();

    // 2: byte-lane merge
    wr(4'd3, 32'hAABBCCDD, 4'b1111);
    wr(4'd3, 32'h11223344, 4'b0101);
    wr(4'd3, 32'hFFFFFFFF, 4'b0000);
    rd(4'd3, 32'hAA22CC44, 32'hAA22CC44);
    drain();

    // 3: read-during-write on the same address
    ce = 1'b1; wr_en = 1'b1; wr_addr = 4'd7; din = 32'hDEADBEEF; wr_be = 4'hF;
    rd(4'd7, 32'h00000000, 32'hDEADBEEF);
    wr_en = 1'b0;
    rd(4'd7, 32'hDEADBEEF, 32'hDEADBEEF);
    ce = 1'b1; wr_en = 1'b1; wr_addr = 4'd7; din = 32'h0000A5A5; wr_be = 4'b0011;
    rd(4'd7, 32'hDEADBEEF, 32'hDEADA5A5);
    wr_en = 1'b0;
    drain();

    // 4: back-to-back reads, latency checked against due cycle
    wr(4'd1, 32'h01010101, 4'hF);
    wr(4'd2, 32'h02020202, 4'hF);
    wr(4'd3, 32'h03030303, 4'hF);
    rd(4'd1, 32'h01010101, 32'h01010101);
    rd(4'd2, 32'h02020202, 32'h02020202);
    rd(4'd3, 32'h03030303, 32'h03030303);
    drain();

    // 6: ce low blocks both ports; dout holds
    wr(4'd4, 32'hCAFEF00D, 4'hF);
    rd(4'd4, 32'hCAFEF00D, 32'hCAFEF00D);
    drain();
    ce = 1'b0; wr_en = 1'b1; wr_addr = 4'd4; din = 32'h12345678; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd4;
    tick();
    idle_inputs();
    drain();
    chk("ce0_hold_a", dout_a, 32'hCAFEF00D);
    chk("ce0_hold_b", dout_b, 32'hCAFEF00D);
    rd(4'd4, 32'hCAFEF00D, 32'hCAFEF00D);
    drain();

    // 5: clear with in-flight read, dropped accesses, reset mid-clear
    for (int i = 0; i < 16; i++) wr(AW'(i), 32'hFFFFFFFF, 4'hF);
    rd(4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF);
    ce = 1'b1; clr_start = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; din = 32'h0; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd2;
    tick();
    idle_inputs();
    wait_clear("clr", 1'b1);
    drain();
    for (int i = 0; i < 16; i++) rd(AW'(i), 32'h0, 32'h0);
    drain();
    wr(4'd6, 32'h600DF00D, 4'hF);
    rd(4'd6, 32'h600DF00D, 32'h600DF00D);
    drain();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick(); tick();
    chk("midrst_dout_a", dout_a, 32'd0);
    chk("midrst_dout_b", dout_b, 32'd0);
    chk("midrst_busy", {30'd0, busy_a, busy_b}, 32'd3);
    reset = 1'b0;
    wait_clear("midrst", 1'b0);
    rd(4'd6, 32'h0, 32'h0);
    rd(4'd15, 32'h0, 32'h0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_dp_be.md
Name: sram_dp_be

Overview:
- Simple dual-port synchronous SRAM: one write port, one read port, both on one clock.
- Successor to the single-port 8x256 SRAM. Adds per-byte write enables, selectable read latency (1 or 2) and selectable read-during-write semantics.
- Replaces the one-cycle whole-array reset with a sequential clear engine that zeroes one word per cycle and reports busy/done.
- Used as generic buffer/register-file storage in small-scale designs.

Parameters:
- DATAWIDTH, 32, word width in bits; must be a multiple of BYTEWIDTH.
- ADDRWIDTH, 6, address width; DEPTH = 2**ADDRWIDTH words.
- BYTEWIDTH, 8, bits per write-enable lane; NBE = DATAWIDTH/BYTEWIDTH.
- RD_LATENCY, 1, cycles from read request to dout_valid; legal values are 1 and 2.
- RDW_MODE, 0, same-address read-during-write: 0 = old data, 1 = new (merged) data.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  chip enable; gates new read/write accesses only.
- wr_en  in  1  write request.
- wr_addr  in  ADDRWIDTH  write address.
- wr_be  in  NBE  byte-lane enables; bit k selects din[k*BYTEWIDTH +: BYTEWIDTH].
- din  in  DATAWIDTH  write data.
- rd_en  in  1  read request.
- rd_addr  in  ADDRWIDTH  read address.
- dout  out  DATAWIDTH  read data.
- dout_valid  out  1  high for exactly one cycle per accepted read.
- clr_start  in  1  request a full-array clear.
- busy  out  1  clear engine active; accesses are blocked while high.
- clr_done  out  1  one-cycle pulse when a clear completes.

Behaviour:
- Reset, on an edge with reset=1:
  - dout=0, dout_valid=0, clr_done=0, read pipeline flushed.
  - busy=1, clear pointer=0.
  - No memory writes occur while reset is held.
- Clear engine, states IDLE and CLEAR:
  - Reset, or clr_start=1 in IDLE, enters CLEAR with ptr=0.
  - In CLEAR: each cycle write 0 to mem[ptr], then ptr++. Once mem[DEPTH-1] is written, go to IDLE.
  - On the IDLE transition edge: busy falls and clr_done=1 for one cycle.
  - busy is therefore high for exactly DEPTH cycles after reset releases, or after the clr_start edge.
  - clr_start is ignored while busy and is independent of ce.
  - clr_start in the same cycle as wr_en/rd_en: the clear wins and the access is dropped.
  - Reset asserted during CLEAR restarts the clear from ptr=0 after release.
- Access acceptance:
  - A write is accepted when ce & wr_en & !busy & !clr_start.
  - A read is accepted when ce & rd_en & !busy & !clr_start.
  - Otherwise the access has no effect and produces no dout_valid.
- Write: on an accepted edge, for each k with wr_be[k]=1, mem[wr_addr] lane k <= din lane k. Lanes with wr_be[k]=0 are unchanged. wr_be=0 is a legal no-op.
- Read latency:
  - RD_LATENCY=1: read accepted at edge t -> dout/dout_valid updated at edge t (visible during cycle t+1).
  - RD_LATENCY=2: adds one output register, so results appear one cycle later.
  - Back-to-back reads produce back-to-back valid data at full throughput.
- Read pipeline: advances every cycle regardless of ce and busy. Reads already in flight when a clear starts complete with their pre-clear data.
- dout holds its last value when no read completes; it is never zeroed by writes. dout_valid=0 on those cycles.
- Same-cycle read and write to the same address:
  - RDW_MODE=0: dout returns the pre-write word.
  - RDW_MODE=1: dout returns the merged word (enabled lanes take din, other lanes take old data).
- Different addresses: the read and write are fully independent.
- Addresses are always in range (full decode); no wrap logic is needed.

Test Plan:
Bench configuration: DATAWIDTH=32, ADDRWIDTH=4 (DEPTH=16).
1. Reset high for 2 cycles, then release -> busy=1 for 16 cycles; clr_done pulses once as busy falls; subsequent read of addr 5 returns 0x00000000 with dout_valid.
2. Write 0xAABBCCDD to addr 3 with be=4'b1111, then 0x11223344 with be=4'b0101 -> read of addr 3 returns 0xAA22CC44.
3. Addr 7 holds 0; write 0xDEADBEEF (be=4'b1111) and read addr 7 in the same cycle -> RDW_MODE=0 gives 0x00000000, RDW_MODE=1 gives 0xDEADBEEF; a following read gives 0xDEADBEEF in both modes.
4. RD_LATENCY=2: reads of addrs 1,2,3 on consecutive cycles starting at edge t -> dout_valid high on edges t+1..t+3 carrying mem[1],mem[2],mem[3]. RD_LATENCY=1 -> the same data one cycle earlier.
5. Fill addrs 0-15 with 0xFFFFFFFF, then assert clr_start together with wr_en to addr 2 -> write dropped; busy high 16 cycles; writes/reads during busy ignored with no dout_valid; afterwards all 16 addrs read 0. Assert reset at clear cycle 5 -> busy stays high 16 cycles after release.
6. ce=0 with wr_en=1 (addr 4, 0x12345678) and rd_en=1 -> mem[4] unchanged, dout_valid=0, dout holds its previous value.
